// File: rtl/multiword_add_sequencer.sv
// rtl/multiword_add_sequencer.sv - word-serial sequencer around a registered WIDTH-bit adder
//
// Purpose:
//   Accepts a WORDS*WIDTH-bit operand pair, feeds it to an external pipelined
//   adder one word at a time (LSW first), chains the carry between words, and
//   returns the full-width sum and carry over a valid/ready handshake.
//   One transaction in flight; each word occupies the adder for ADD_LAT+1 cycles.
//
// Configuration macro:
//   MULTIWORD_ADD_SEQUENCER_OVF_EN - adds ovf_o, the signed overflow of the full add.
//
// Ports:
//   CLK_i        in   clock, rising edge
//   RST_N_I      in   asynchronous active-low reset
//   in_valid_i   in   operand pair valid
//   in_ready_o   out  sequencer idle, can accept an operand pair
//   op_a_i       in   operand A (WORDS*WIDTH)
//   op_b_i       in   operand B (WORDS*WIDTH)
//   carry_in_i   in   carry into word 0
//   add_a_o      out  A word to the adder
//   add_b_o      out  B word to the adder
//   add_p_o      out  carry-in to the adder
//   add_s_i      in   adder sum word
//   add_c_i      in   adder carry-out
//   out_valid_o  out  result valid
//   out_ready_i  in   consumer accepts result
//   sum_o        out  full sum (WORDS*WIDTH)
//   carry_o      out  carry out of the MSW
//   busy_o       out  transaction in progress (RUN or DONE)
//   ovf_o        out  signed overflow (only with MULTIWORD_ADD_SEQUENCER_OVF_EN)

module multiword_add_sequencer #(
  parameter int WIDTH   = 8,
  parameter int WORDS   = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                   CLK_i,
  input  logic                   RST_N_I,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WORDS*WIDTH-1:0] op_a_i,
  input  logic [WORDS*WIDTH-1:0] op_b_i,
  input  logic                   carry_in_i,
  output logic [WIDTH-1:0]       add_a_o,
  output logic [WIDTH-1:0]       add_b_o,
  output logic                   add_p_o,
  input  logic [WIDTH-1:0]       add_s_i,
  input  logic                   add_c_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WORDS*WIDTH-1:0] sum_o,
  output logic                   carry_o,
`ifdef MULTIWORD_ADD_SEQUENCER_OVF_EN
  output logic                   ovf_o,
`endif
  output logic                   busy_o
);

  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [KW-1:0]                k_q;
  logic [LW-1:0]                lat_q;
  logic [WORDS-1:0][WIDTH-1:0]  a_q;
  logic [WORDS-1:0][WIDTH-1:0]  b_q;
  logic [WORDS-1:0][WIDTH-1:0]  sum_q;
  // Holds carry_in_i after accept, then the carry-out of each completed word;
  // after the last word it is the final carry.
  logic                         cy_q;

  logic last_beat;
  logic last_word;

  // The adder result for the current word is valid in the last of the
  // ADD_LAT+1 cycles the word is held.
  assign last_beat = (state_q == S_RUN) && (lat_q == LW'(ADD_LAT));
  assign last_word = (k_q == KW'(WORDS - 1));

  always_ff @(posedge CLK_i or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    add_a_o     = '0;
    add_b_o     = '0;
    add_p_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (in_valid_i) state_d = S_RUN;
      end
      S_RUN: begin
        add_a_o = a_q[k_q];
        add_b_o = b_q[k_q];
        add_p_o = cy_q;
        if (last_beat && last_word) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_i or negedge RST_N_I) begin
    if (!RST_N_I) begin
      k_q   <= '0;
      lat_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      cy_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && in_valid_i) begin
        a_q   <= op_a_i;
        b_q   <= op_b_i;
        cy_q  <= carry_in_i;
        k_q   <= '0;
        lat_q <= '0;
      end else if (state_q == S_RUN) begin
        if (last_beat) begin
          lat_q      <= '0;
          sum_q[k_q] <= add_s_i;
          cy_q       <= add_c_i;
          if (!last_word) k_q <= k_q + KW'(1);
        end else begin
          lat_q <= lat_q + LW'(1);
        end
      end
    end
  end

  assign sum_o   = sum_q;
  assign carry_o = cy_q;

`ifdef MULTIWORD_ADD_SEQUENCER_OVF_EN
  logic ovf_q;

  // Signed overflow: operands share a sign and the MSW result sign differs.
  always_ff @(posedge CLK_i or negedge RST_N_I) begin
    if (!RST_N_I) begin
      ovf_q <= 1'b0;
    end else if (last_beat && last_word) begin
      ovf_q <= (a_q[WORDS-1][WIDTH-1] == b_q[WORDS-1][WIDTH-1]) &&
               (add_s_i[WIDTH-1] != a_q[WORDS-1][WIDTH-1]);
    end
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb/tb_multiword_add_sequencer.sv - directed self-checking bench for multiword_add_sequencer

module tb_multiword_add_sequencer;

  localparam int W = 8;
  localparam int N = 4;
  localparam int L = 2;

  logic           CLK_i   = 1'b0;
  logic           RST_N_I = 1'b0;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [N*W-1:0] op_a_i;
  logic [N*W-1:0] op_b_i;
  logic           carry_in_i;
  logic [W-1:0]   add_a_o;
  logic [W-1:0]   add_b_o;
  logic           add_p_o;
  logic [W-1:0]   add_s_i;
  logic           add_c_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [N*W-1:0] sum_o;
  logic           carry_o;
  logic           busy_o;
`ifdef MULTIWORD_ADD_SEQUENCER_OVF_EN
  logic           ovf_o;
`endif

  multiword_add_sequencer #(.WIDTH(W), .WORDS(N), .ADD_LAT(L)) dut (
    .CLK_i       (CLK_i),
    .RST_N_I     (RST_N_I),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .carry_in_i  (carry_in_i),
    .add_a_o     (add_a_o),
    .add_b_o     (add_b_o),
    .add_p_o     (add_p_o),
    .add_s_i     (add_s_i),
    .add_c_i     (add_c_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sum_o       (sum_o),
    .carry_o     (carry_o),
`ifdef MULTIWORD_ADD_SEQUENCER_OVF_EN
    .ovf_o       (ovf_o),
`endif
    .busy_o      (busy_o)
  );

  always #5 CLK_i = ~CLK_i;

  // Two-cycle registered adder model.
  logic [W:0] st1, st2;
  always @(posedge CLK_i) begin
    st1 <= {1'b0, add_a_o} + {1'b0, add_b_o} + {{W{1'b0}}, add_p_o};
    st2 <= st1;
  end
  assign add_s_i = st2[W-1:0];
  assign add_c_i = st2[W];

  int cyc = 0;
  always @(posedge CLK_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents operands in an IDLE cycle; returns just after the accept edge.
  task automatic start(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                       input logic c, output int acc);
    op_a_i     = a;
    op_b_i     = b;
    carry_in_i = c;
    in_valid_i = 1'b1;
    @(negedge CLK_i);
    check("in_ready_at_accept", {63'd0, in_ready_o}, 64'd1);
    acc = cyc;
    @(posedge CLK_i);
    #1;
  endtask

  // Returns at the negedge of the first cycle with out_valid_o high.
  task automatic wait_done(input int acc, output int lat, output logic [3:0] pseq);
    pseq = 4'b0000;
    lat  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK_i);
      lat = cyc - acc;
      if (lat >= 1 && lat <= 10 && ((lat - 1) % 3) == 0) pseq[(lat - 1) / 3] = add_p_o;
      if (out_valid_o) break;
    end
  endtask

  logic last_ovf;

  task automatic run(input string tag, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                     input logic c, input logic [N*W-1:0] es, input logic ec,
                     output logic [3:0] pseq);
    int acc, lat;
    start(a, b, c, acc);
    in_valid_i = 1'b0;
    wait_done(acc, lat, pseq);
    check({tag, "_latency"}, 64'(lat), 64'd13);
    check({tag, "_sum"}, 64'(sum_o), 64'(es));
    check({tag, "_carry"}, {63'd0, carry_o}, {63'd0, ec});
`ifdef MULTIWORD_ADD_SEQUENCER_OVF_EN
    last_ovf = ovf_o;
`else
    last_ovf = 1'b0;
`endif
    @(posedge CLK_i);
    #1;
  endtask

  logic [N*W-1:0] va [3];
  logic [N*W-1:0] vb [3];
  logic           vc [3];
  logic [N*W-1:0] vs [3];
  logic           vk [3];

  initial begin
    int acc, prev, lat;
    logic [3:0] pseq;

    in_valid_i  = 1'b0;
    op_a_i      = '0;
    op_b_i      = '0;
    carry_in_i  = 1'b0;
    out_ready_i = 1'b1;

    // Reset state
    repeat (2) @(posedge CLK_i);
    @(negedge CLK_i);
    check("rst_in_ready",  {63'd0, in_ready_o},  64'd1);
    check("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("rst_busy",      {63'd0, busy_o},      64'd0);
    check("rst_add_a",     64'(add_a_o),         64'd0);
    check("rst_add_b",     64'(add_b_o),         64'd0);
    check("rst_add_p",     {63'd0, add_p_o},     64'd0);
    check("rst_sum",       64'(sum_o),           64'd0);
    check("rst_carry",     {63'd0, carry_o},     64'd0);
    @(posedge CLK_i);
    #1;
    RST_N_I = 1'b1;
    @(posedge CLK_i);
    #1;

    // Reset mid-RUN, three cycles after accept
    start(32'hAAAA5555, 32'h5555AAAA, 1'b1, acc);
    in_valid_i = 1'b0;
    repeat (2) @(posedge CLK_i);
    #1;
    check("midrun_busy", {63'd0, busy_o}, 64'd1);
    RST_N_I = 1'b0;
    #2;
    check("midrst_in_ready",  {63'd0, in_ready_o},  64'd1);
    check("midrst_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("midrst_busy",      {63'd0, busy_o},      64'd0);
    check("midrst_add_a",     64'(add_a_o),         64'd0);
    check("midrst_add_p",     {63'd0, add_p_o},     64'd0);
    check("midrst_sum",       64'(sum_o),           64'd0);
    check("midrst_carry",     {63'd0, carry_o},     64'd0);
    @(posedge CLK_i);
    #1;
    RST_N_I = 1'b1;
    @(negedge CLK_i);
    check("postrst_in_ready", {63'd0, in_ready_o}, 64'd1);
    @(posedge CLK_i);
    #1;
    run("after_rst", 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, pseq);

    // Full carry ripple through every word
    run("ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, pseq);

    // Per-word carry-in sequence
    run("pseq", 32'h00FF00FF, 32'h00010000, 1'b1, 32'h01000100, 1'b0, pseq);
    check("pseq_add_p", 64'(pseq), 64'(4'b1011));

    // All-ones + all-ones + 1
    run("allones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, pseq);

    // Backpressure in DONE
    out_ready_i = 1'b0;
    start(32'hDEADBEEF, 32'h11111111, 1'b0, acc);
    in_valid_i = 1'b0;
    wait_done(acc, lat, pseq);
    check("bp_latency", 64'(lat), 64'd13);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK_i);
      #1;
      in_valid_i = (i % 2) == 0;
      op_a_i     = 32'h01010101;
      op_b_i     = 32'h02020202;
      @(negedge CLK_i);
      check("bp_sum",       64'(sum_o),           64'h00000000EFBED000);
      check("bp_carry",     {63'd0, carry_o},     64'd0);
      check("bp_in_ready",  {63'd0, in_ready_o},  64'd0);
      check("bp_out_valid", {63'd0, out_valid_o}, 64'd1);
    end
    @(posedge CLK_i);
    #1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(negedge CLK_i);
    check("bp_release_valid", {63'd0, out_valid_o}, 64'd1);
    @(posedge CLK_i);
    #1;
    @(negedge CLK_i);
    check("bp_after_valid",    {63'd0, out_valid_o}, 64'd0);
    check("bp_after_busy",     {63'd0, busy_o},      64'd0);
    check("bp_after_in_ready", {63'd0, in_ready_o},  64'd1);
    check("bp_after_sum",      64'(sum_o),           64'h00000000EFBED000);
    @(posedge CLK_i);
    #1;

    // Back-to-back with in_valid_i held high
    va[0] = 32'h01020304; vb[0] = 32'h10203040; vc[0] = 1'b0; vs[0] = 32'h11223344; vk[0] = 1'b0;
    va[1] = 32'h80000000; vb[1] = 32'h80000000; vc[1] = 1'b1; vs[1] = 32'h00000001; vk[1] = 1'b1;
    va[2] = 32'hFFFF0000; vb[2] = 32'h0000FFFF; vc[2] = 1'b0; vs[2] = 32'hFFFFFFFF; vk[2] = 1'b0;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      start(va[i], vb[i], vc[i], acc);
      if (i > 0) check("b2b_spacing", 64'(acc - prev), 64'd14);
      prev = acc;
      wait_done(acc, lat, pseq);
      check("b2b_latency", 64'(lat), 64'd13);
      check("b2b_sum",     64'(sum_o),       64'(vs[i]));
      check("b2b_carry",   {63'd0, carry_o}, {63'd0, vk[i]});
      @(posedge CLK_i);
      #1;
    end
    in_valid_i = 1'b0;
    @(negedge CLK_i);
    check("b2b_end_idle", {63'd0, busy_o}, 64'd0);
    @(posedge CLK_i);
    #1;

`ifdef MULTIWORD_ADD_SEQUENCER_OVF_EN
    run("ovf_pos", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, pseq);
    check("ovf_pos_flag", {63'd0, last_ovf}, 64'd1);
    run("ovf_neg", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, pseq);
    check("ovf_neg_flag", {63'd0, last_ovf}, 64'd1);
    run("ovf_none", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, pseq);
    check("ovf_none_flag", {63'd0, last_ovf}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
